id_ex_pipe: RTL and testbench
=============================

Name: id_ex_pipe

Overview:
- ID/EX pipeline register of the 5-stage RV32 core.
- Captures decoded operands and control from ID and presents them to EX, to the forwarding logic (EX_Rs1_o/EX_Rs2_o) and to the ALU path.
- Contains load-use hazard detection. It inserts a one-cycle bubble and freezes PC and IF/ID when the EX instruction is a load whose Rd is read by the ID instruction.
- Also handles branch flush and external whole-pipe stall.

Parameters:
XLEN, 32, datapath width
REG_AW, 5, register index width

Ports:
clk_i  in  1  clock
rst_n_i  in  1  asynchronous active-low reset
ID_valid_i  in  1  ID holds a real instruction
ID_PC_i  in  XLEN  PC of ID instruction
ID_RS1data_i  in  XLEN  register file read 1
ID_RS2data_i  in  XLEN  register file read 2
ID_Imm_i  in  XLEN  sign-extended immediate
ID_Rs1_i  in  REG_AW  source 1 index
ID_Rs2_i  in  REG_AW  source 2 index
ID_Rd_i  in  REG_AW  destination index
ID_funct_i  in  10  {funct7,funct3}
ID_RegWrite_i, ID_MemtoReg_i, ID_MemRead_i, ID_MemWrite_i, ID_ALUSrc_i  in  1 each  control
ID_ALUOp_i  in  2  ALU op class
Flush_i  in  1  squash ID instruction (taken branch)
Stall_ext_i  in  1  freeze entire pipe (memory wait)
EX_valid_o  out  1  EX holds a real instruction
EX_PC_o, EX_RS1data_o, EX_RS2data_o, EX_Imm_o  out  XLEN  registered copies
EX_Rs1_o, EX_Rs2_o, EX_Rd_o  out  REG_AW  registered copies
EX_funct_o  out  10  registered copy
EX_RegWrite_o, EX_MemtoReg_o, EX_MemRead_o, EX_MemWrite_o, EX_ALUSrc_o  out  1 each  registered control
EX_ALUOp_o  out  2  registered control
Hazard_o  out  1  load-use detected this cycle
PCWrite_o  out  1  PC update enable
IFIDWrite_o  out  1  IF/ID register enable

Behaviour:
Reset:
- rst_n_i low asynchronously clears every EX_* output and EX_valid_o to 0.
- Reset is honoured mid-operation. No pending state survives it.

Load-use detection (combinational from registered EX state and current ID inputs):
- hazard = EX_valid_o & EX_MemRead_o & (EX_Rd_o != 0) & ID_valid_i & ~Flush_i & ((EX_Rd_o == ID_Rs1_i) | (EX_Rd_o == ID_Rs2_i)).
- Hazard_o = hazard & ~Stall_ext_i.
- PCWrite_o = IFIDWrite_o = ~Hazard_o & ~Stall_ext_i.

Register update at posedge, priority order:
1. Stall_ext_i=1: all EX_* hold their values.
2. Flush_i=1: bubble.
3. hazard=1: bubble.
4. Otherwise: load all ID fields; EX_valid_o <= ID_valid_i.

Bubble definition:
- EX_valid_o and all six control outputs (RegWrite, MemtoReg, MemRead, MemWrite, ALUSrc, ALUOp) are cleared.
- Data, index and PC fields load from ID as normal. They are don't-care but deterministic.

Timing and boundary rules:
- Latency is 1 cycle ID to EX.
- Hazard lasts exactly 1 cycle: after the bubble, the load has left EX, so the held ID instruction loads on the next edge.
- Back-to-back loads to the same Rd each stall once.
- Flush and hazard in the same cycle: flush wins; PCWrite_o stays 1.
- Stall_ext_i with hazard: no bubble is counted and no state advances. The hazard re-evaluates after the stall ends.
- ID_valid_i=0 never raises a hazard and loads a bubble.

Optional Feature:
- Macro ID_EX_PERF_CNT_EN.
- Defined:
  - Adds output Bubble_cnt_o [31:0], cleared on reset.
  - Increments by 1 on every edge that inserts a load-use bubble (Stall_ext_i=0 & hazard). Flush bubbles are not counted.
  - Wraps from 0xFFFFFFFF to 0.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Shared package pipe_pkg holds:
  - REG_AW and XLEN defaults.
  - ALUOp encodings (2'b00 add/load-store, 2'b01 branch, 2'b10 R-type, 2'b11 I-type).
  - A packed control-bundle typedef (RegWrite, MemtoReg, MemRead, MemWrite, ALUSrc, ALUOp).
  - Constant CTRL_NOP (all zero).
- One sub-module: load_use_detect, the purely combinational hazard equation, reused by future pipe variants. Registers stay in id_ex_pipe.

Test Plan:
- Reset mid-stream: load PC=0x40 with RegWrite=1, assert rst_n_i low between edges -> all EX_* = 0 immediately, Hazard_o=0.
- EX holds lw x5 (MemRead=1, Rd=5); ID add with Rs1=5 -> Hazard_o=1, PCWrite_o=0, IFIDWrite_o=0. Next cycle EX_valid_o=0, all ctrl 0, Hazard_o=0. Following edge EX_Rs1_o=5 with add controls.
- EX holds lw x0; ID Rs1=0, Rs2=0 -> Hazard_o=0, PCWrite_o=1, ID instruction loads next edge.
- EX holds lw x7; ID Rs2=7 with Flush_i=1 -> Hazard_o=0, PCWrite_o=1, next EX_valid_o=0, EX_RegWrite_o=0.
- Stall_ext_i=1 for 3 cycles with changing ID inputs -> EX_* constant, PCWrite_o=0; on release, the current ID fields load on the next edge.
- With ID_EX_PERF_CNT_EN: two separate load-use hazards plus one flush -> Bubble_cnt_o=2. Preload 0xFFFFFFFF via force, one hazard -> Bubble_cnt_o=0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the RV32 pipeline registers: default widths,
// ALUOp class encodings and the packed control bundle carried between stages.
package pipe_pkg;

  localparam int XLEN_DEF   = 32;
  localparam int REG_AW_DEF = 5;

  // ALUOp classes decoded further by the ALU control unit
  localparam logic [1:0] ALUOP_ADD    = 2'b00;  // address calc for load/store
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
  localparam logic [1:0] ALUOP_ITYPE  = 2'b11;

  // Control bundle; field order matches the packing used at the ID inputs
  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic       mem_read;
    logic       mem_write;
    logic       alu_src;
    logic [1:0] alu_op;
  } ctrl_t;

  // Bubble control: no side effects anywhere downstream
  localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard check: the instruction in EX is a load whose
// non-zero destination is read by the real, unflushed instruction in ID.
module load_use_detect #(
  parameter int REG_AW = 5
) (
  input  logic              ex_valid,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              id_valid,
  input  logic              flush,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  output logic              hazard
);

  logic ex_is_load;
  logic id_reads_rd;

  // x0 never carries a real dependency, so a load to x0 cannot stall
  assign ex_is_load  = ex_valid & ex_mem_read & (ex_rd != '0);
  assign id_reads_rd = (ex_rd == id_rs1) | (ex_rd == id_rs2);
  assign hazard      = ex_is_load & id_valid & ~flush & id_reads_rd;

endmodule

// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register with load-use bubble insertion, branch flush and
// whole-pipe external stall. Optional load-use bubble counter is enabled by
// defining ID_EX_PERF_CNT_EN (adds port Bubble_cnt_o).
module id_ex_pipe
  import pipe_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              ID_valid_i,
  input  logic [XLEN-1:0]   ID_PC_i,
  input  logic [XLEN-1:0]   ID_RS1data_i,
  input  logic [XLEN-1:0]   ID_RS2data_i,
  input  logic [XLEN-1:0]   ID_Imm_i,
  input  logic [REG_AW-1:0] ID_Rs1_i,
  input  logic [REG_AW-1:0] ID_Rs2_i,
  input  logic [REG_AW-1:0] ID_Rd_i,
  input  logic [9:0]        ID_funct_i,
  input  logic              ID_RegWrite_i,
  input  logic              ID_MemtoReg_i,
  input  logic              ID_MemRead_i,
  input  logic              ID_MemWrite_i,
  input  logic              ID_ALUSrc_i,
  input  logic [1:0]        ID_ALUOp_i,
  input  logic              Flush_i,
  input  logic              Stall_ext_i,
  output logic              EX_valid_o,
  output logic [XLEN-1:0]   EX_PC_o,
  output logic [XLEN-1:0]   EX_RS1data_o,
  output logic [XLEN-1:0]   EX_RS2data_o,
  output logic [XLEN-1:0]   EX_Imm_o,
  output logic [REG_AW-1:0] EX_Rs1_o,
  output logic [REG_AW-1:0] EX_Rs2_o,
  output logic [REG_AW-1:0] EX_Rd_o,
  output logic [9:0]        EX_funct_o,
  output logic              EX_RegWrite_o,
  output logic              EX_MemtoReg_o,
  output logic              EX_MemRead_o,
  output logic              EX_MemWrite_o,
  output logic              EX_ALUSrc_o,
  output logic [1:0]        EX_ALUOp_o,
`ifdef ID_EX_PERF_CNT_EN
  output logic [31:0]       Bubble_cnt_o,
`endif
  output logic              Hazard_o,
  output logic              PCWrite_o,
  output logic              IFIDWrite_o
);

  logic              ex_valid_reg, ex_valid_next;
  logic [XLEN-1:0]   ex_pc_reg, ex_rs1data_reg, ex_rs2data_reg, ex_imm_reg;
  logic [REG_AW-1:0] ex_rs1_reg, ex_rs2_reg, ex_rd_reg;
  logic [9:0]        ex_funct_reg;
  ctrl_t             ex_ctrl_reg, ex_ctrl_next;
  ctrl_t             id_ctrl;
  logic              hazard;
  logic              bubble;

  assign id_ctrl = {ID_RegWrite_i, ID_MemtoReg_i, ID_MemRead_i,
                    ID_MemWrite_i, ID_ALUSrc_i, ID_ALUOp_i};

  load_use_detect #(.REG_AW(REG_AW)) u_load_use_detect (
    .ex_valid    (ex_valid_reg),
    .ex_mem_read (ex_ctrl_reg.mem_read),
    .ex_rd       (ex_rd_reg),
    .id_valid    (ID_valid_i),
    .flush       (Flush_i),
    .id_rs1      (ID_Rs1_i),
    .id_rs2      (ID_Rs2_i),
    .hazard      (hazard)
  );

  // An external stall freezes everything, so no hazard is reported meanwhile
  assign Hazard_o    = hazard & ~Stall_ext_i;
  assign PCWrite_o   = ~Hazard_o & ~Stall_ext_i;
  assign IFIDWrite_o = ~Hazard_o & ~Stall_ext_i;

  // Flush, load-use and an empty ID slot all become a control-free bubble
  assign bubble = Flush_i | hazard | ~ID_valid_i;

  // Select what EX receives: real controls or the NOP bundle
  always_comb begin
    ex_ctrl_next  = id_ctrl;
    ex_valid_next = 1'b1;
    if (bubble) begin
      ex_ctrl_next  = CTRL_NOP;
      ex_valid_next = 1'b0;
    end
  end

  // Pipeline register; data fields load even on a bubble to stay deterministic
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ex_valid_reg   <= 1'b0;
      ex_pc_reg      <= '0;
      ex_rs1data_reg <= '0;
      ex_rs2data_reg <= '0;
      ex_imm_reg     <= '0;
      ex_rs1_reg     <= '0;
      ex_rs2_reg     <= '0;
      ex_rd_reg      <= '0;
      ex_funct_reg   <= '0;
      ex_ctrl_reg    <= CTRL_NOP;
    end else if (!Stall_ext_i) begin
      ex_valid_reg   <= ex_valid_next;
      ex_pc_reg      <= ID_PC_i;
      ex_rs1data_reg <= ID_RS1data_i;
      ex_rs2data_reg <= ID_RS2data_i;
      ex_imm_reg     <= ID_Imm_i;
      ex_rs1_reg     <= ID_Rs1_i;
      ex_rs2_reg     <= ID_Rs2_i;
      ex_rd_reg      <= ID_Rd_i;
      ex_funct_reg   <= ID_funct_i;
      ex_ctrl_reg    <= ex_ctrl_next;
    end
  end

`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] bubble_cnt_reg;

  // Count only load-use bubbles that actually get inserted; wraps naturally
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      bubble_cnt_reg <= '0;
    end else if (hazard && !Stall_ext_i) begin
      bubble_cnt_reg <= bubble_cnt_reg + 32'd1;
    end
  end

  assign Bubble_cnt_o = bubble_cnt_reg;
`endif

  assign EX_valid_o    = ex_valid_reg;
  assign EX_PC_o       = ex_pc_reg;
  assign EX_RS1data_o  = ex_rs1data_reg;
  assign EX_RS2data_o  = ex_rs2data_reg;
  assign EX_Imm_o      = ex_imm_reg;
  assign EX_Rs1_o      = ex_rs1_reg;
  assign EX_Rs2_o      = ex_rs2_reg;
  assign EX_Rd_o       = ex_rd_reg;
  assign EX_funct_o    = ex_funct_reg;
  assign EX_RegWrite_o = ex_ctrl_reg.reg_write;
  assign EX_MemtoReg_o = ex_ctrl_reg.mem_to_reg;
  assign EX_MemRead_o  = ex_ctrl_reg.mem_read;
  assign EX_MemWrite_o = ex_ctrl_reg.mem_write;
  assign EX_ALUSrc_o   = ex_ctrl_reg.alu_src;
  assign EX_ALUOp_o    = ex_ctrl_reg.alu_op;

endmodule

// File: tb/tb_id_ex_pipe.sv
// Scoreboard bench for id_ex_pipe: the stimulus process predicts the
// combinational hazard outputs and the next EX contents from a behavioural
// model; a monitor process pops and compares them.
module tb_id_ex_pipe;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc, rs1d, rs2d, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [9:0]  funct;
    logic        rw, mtr, mr, mw, as;
    logic [1:0]  aluop;
    logic        flush, stall;
  } id_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc, rs1d, rs2d, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [9:0]  funct;
    logic        rw, mtr, mr, mw, as;
    logic [1:0]  aluop;
  } ex_t;

  typedef struct packed {
    logic hazard, pcw, ifidw;
  } comb_t;

  typedef struct packed {
    ex_t         ex;
    logic [31:0] cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        ID_valid_i = 1'b0;
  logic [31:0] ID_PC_i = '0, ID_RS1data_i = '0, ID_RS2data_i = '0, ID_Imm_i = '0;
  logic [4:0]  ID_Rs1_i = '0, ID_Rs2_i = '0, ID_Rd_i = '0;
  logic [9:0]  ID_funct_i = '0;
  logic        ID_RegWrite_i = 1'b0, ID_MemtoReg_i = 1'b0, ID_MemRead_i = 1'b0;
  logic        ID_MemWrite_i = 1'b0, ID_ALUSrc_i = 1'b0;
  logic [1:0]  ID_ALUOp_i = '0;
  logic        Flush_i = 1'b0, Stall_ext_i = 1'b0;

  logic        EX_valid_o;
  logic [31:0] EX_PC_o, EX_RS1data_o, EX_RS2data_o, EX_Imm_o;
  logic [4:0]  EX_Rs1_o, EX_Rs2_o, EX_Rd_o;
  logic [9:0]  EX_funct_o;
  logic        EX_RegWrite_o, EX_MemtoReg_o, EX_MemRead_o, EX_MemWrite_o, EX_ALUSrc_o;
  logic [1:0]  EX_ALUOp_o;
  logic        Hazard_o, PCWrite_o, IFIDWrite_o;
  logic [31:0] bubble_cnt;

  always #5 clk = ~clk;

  id_ex_pipe dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n_i),
    .ID_valid_i    (ID_valid_i),
    .ID_PC_i       (ID_PC_i),
    .ID_RS1data_i  (ID_RS1data_i),
    .ID_RS2data_i  (ID_RS2data_i),
    .ID_Imm_i      (ID_Imm_i),
    .ID_Rs1_i      (ID_Rs1_i),
    .ID_Rs2_i      (ID_Rs2_i),
    .ID_Rd_i       (ID_Rd_i),
    .ID_funct_i    (ID_funct_i),
    .ID_RegWrite_i (ID_RegWrite_i),
    .ID_MemtoReg_i (ID_MemtoReg_i),
    .ID_MemRead_i  (ID_MemRead_i),
    .ID_MemWrite_i (ID_MemWrite_i),
    .ID_ALUSrc_i   (ID_ALUSrc_i),
    .ID_ALUOp_i    (ID_ALUOp_i),
    .Flush_i       (Flush_i),
    .Stall_ext_i   (Stall_ext_i),
    .EX_valid_o    (EX_valid_o),
    .EX_PC_o       (EX_PC_o),
    .EX_RS1data_o  (EX_RS1data_o),
    .EX_RS2data_o  (EX_RS2data_o),
    .EX_Imm_o      (EX_Imm_o),
    .EX_Rs1_o      (EX_Rs1_o),
    .EX_Rs2_o      (EX_Rs2_o),
    .EX_Rd_o       (EX_Rd_o),
    .EX_funct_o    (EX_funct_o),
    .EX_RegWrite_o (EX_RegWrite_o),
    .EX_MemtoReg_o (EX_MemtoReg_o),
    .EX_MemRead_o  (EX_MemRead_o),
    .EX_MemWrite_o (EX_MemWrite_o),
    .EX_ALUSrc_o   (EX_ALUSrc_o),
    .EX_ALUOp_o    (EX_ALUOp_o),
`ifdef ID_EX_PERF_CNT_EN
    .Bubble_cnt_o  (bubble_cnt),
`endif
    .Hazard_o      (Hazard_o),
    .PCWrite_o     (PCWrite_o),
    .IFIDWrite_o   (IFIDWrite_o)
  );

`ifndef ID_EX_PERF_CNT_EN
  assign bubble_cnt = '0;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  comb_t comb_q[$];
  exp_t  ex_q[$];

  // Reference state: what EX should hold and how many load-use stalls occurred
  ex_t         m_ex  = '0;
  logic [31:0] m_cnt = '0;

  function automatic ex_t dut_ex();
    return {EX_valid_o, EX_PC_o, EX_RS1data_o, EX_RS2data_o, EX_Imm_o,
            EX_Rs1_o, EX_Rs2_o, EX_Rd_o, EX_funct_o, EX_RegWrite_o,
            EX_MemtoReg_o, EX_MemRead_o, EX_MemWrite_o, EX_ALUSrc_o, EX_ALUOp_o};
  endfunction

  // A stall is needed when EX is loading a real register the ID instruction reads
  function automatic logic model_hazard(input id_t d);
    logic ex_loads_reg;
    logic id_needs_it;
    ex_loads_reg = m_ex.valid && m_ex.mr && (m_ex.rd != 5'd0);
    id_needs_it  = d.valid && !d.flush && (d.rs1 == m_ex.rd || d.rs2 == m_ex.rd);
    return ex_loads_reg && id_needs_it;
  endfunction

  function automatic id_t rand_id();
    id_t d;
    d.valid = ($urandom_range(0, 99) < 85);
    d.pc    = $urandom & 32'hFFFF_FFFC;
    d.rs1d  = $urandom;
    d.rs2d  = $urandom;
    d.imm   = $urandom;
    d.rs1   = 5'($urandom_range(0, 7));
    d.rs2   = 5'($urandom_range(0, 7));
    d.rd    = 5'($urandom_range(0, 7));
    d.funct = 10'($urandom);
    d.rw    = 1'($urandom);
    d.mtr   = 1'($urandom);
    d.mr    = ($urandom_range(0, 99) < 40);
    d.mw    = 1'($urandom);
    d.as    = 1'($urandom);
    d.aluop = 2'($urandom);
    d.flush = ($urandom_range(0, 99) < 10);
    d.stall = ($urandom_range(0, 99) < 15);
    return d;
  endfunction

  function automatic id_t mk(input logic [31:0] pc, input logic [4:0] rs1,
                             input logic [4:0] rs2, input logic [4:0] rd,
                             input logic is_load, input logic flush,
                             input logic stall);
    id_t d;
    d       = rand_id();
    d.valid = 1'b1;
    d.pc    = pc;
    d.rs1   = rs1;
    d.rs2   = rs2;
    d.rd    = rd;
    d.rw    = 1'b1;
    d.mtr   = is_load;
    d.mr    = is_load;
    d.mw    = 1'b0;
    d.as    = is_load;
    d.aluop = is_load ? 2'b00 : 2'b10;
    d.flush = flush;
    d.stall = stall;
    return d;
  endfunction

  // Drive one ID cycle, record predictions, and advance to the next drive phase
  task automatic step(input id_t d);
    comb_t c;
    exp_t  e;
    logic  hz;
    ID_valid_i = d.valid;   ID_PC_i = d.pc;
    ID_RS1data_i = d.rs1d;  ID_RS2data_i = d.rs2d;  ID_Imm_i = d.imm;
    ID_Rs1_i = d.rs1;       ID_Rs2_i = d.rs2;       ID_Rd_i = d.rd;
    ID_funct_i = d.funct;   ID_RegWrite_i = d.rw;   ID_MemtoReg_i = d.mtr;
    ID_MemRead_i = d.mr;    ID_MemWrite_i = d.mw;   ID_ALUSrc_i = d.as;
    ID_ALUOp_i = d.aluop;   Flush_i = d.flush;      Stall_ext_i = d.stall;

    hz       = model_hazard(d);
    c.hazard = hz && !d.stall;
    c.pcw    = !c.hazard && !d.stall;
    c.ifidw  = c.pcw;
    comb_q.push_back(c);

    if (!d.stall) begin
      m_ex.pc = d.pc;     m_ex.rs1d = d.rs1d;  m_ex.rs2d = d.rs2d;
      m_ex.imm = d.imm;   m_ex.rs1 = d.rs1;    m_ex.rs2 = d.rs2;
      m_ex.rd = d.rd;     m_ex.funct = d.funct;
      if (d.valid && !d.flush && !hz) begin
        m_ex.valid = 1'b1;
        m_ex.rw = d.rw;  m_ex.mtr = d.mtr;  m_ex.mr = d.mr;
        m_ex.mw = d.mw;  m_ex.as = d.as;    m_ex.aluop = d.aluop;
      end else begin
        m_ex.valid = 1'b0;
        m_ex.rw = 1'b0;  m_ex.mtr = 1'b0;  m_ex.mr = 1'b0;
        m_ex.mw = 1'b0;  m_ex.as = 1'b0;   m_ex.aluop = 2'b00;
      end
      if (hz) m_cnt = m_cnt + 32'd1;
    end
    e.ex  = m_ex;
    e.cnt = m_cnt;
    ex_q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  // Assert reset between edges and confirm it takes effect without a clock
  task automatic do_reset();
    rst_n_i = 1'b0;
    #1;
    m_ex  = '0;
    m_cnt = '0;
    n_checks++;
    if (dut_ex() !== ex_t'(0) || Hazard_o !== 1'b0 || bubble_cnt !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_state: got ex=%h hazard=%b cnt=%h, want all zero",
               dut_ex(), Hazard_o, bubble_cnt);
    end
    @(posedge clk);
    #2;
    rst_n_i = 1'b1;
  endtask

  // Monitor: combinational outputs at the falling edge, EX state just after rising
  initial begin
    comb_t c;
    exp_t  e;
    forever begin
      @(negedge clk);
      if (comb_q.size() != 0) begin
        c = comb_q.pop_front();
        n_checks++;
        if ({Hazard_o, PCWrite_o, IFIDWrite_o} !== c) begin
          n_fail++;
          $display("FAIL hazard_pcw_ifidw @%0t: got %b%b%b want %b", $time,
                   Hazard_o, PCWrite_o, IFIDWrite_o, c);
        end else
          $display("check comb @%0t hazard=%b pcwrite=%b", $time, Hazard_o, PCWrite_o);
      end
      @(posedge clk);
      #1;
      if (ex_q.size() != 0) begin
        e = ex_q.pop_front();
        n_checks++;
        if (dut_ex() !== e.ex) begin
          n_fail++;
          $display("FAIL ex_state @%0t: got %h want %h", $time, dut_ex(), e.ex);
        end else
          $display("check ex @%0t valid=%b pc=%h rd=%0d", $time, EX_valid_o, EX_PC_o, EX_Rd_o);
`ifdef ID_EX_PERF_CNT_EN
        n_checks++;
        if (bubble_cnt !== e.cnt) begin
          n_fail++;
          $display("FAIL bubble_cnt @%0t: got %h want %h", $time, bubble_cnt, e.cnt);
        end
`endif
      end
    end
  end

  initial begin
    id_t d;
    #3;
    do_reset();  // reset asserted from time 0; checks the cleared state

    // Mid-stream reset after a real instruction with RegWrite lands in EX
    step(mk(32'h40, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0));
    do_reset();

    // Load-use: lw x5 then add reading x5 -> one bubble, then the add loads
    step(mk(32'h100, 5'd2, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0));
    d = mk(32'h104, 5'd5, 5'd3, 5'd6, 1'b0, 1'b0, 1'b0);
    step(d);
    step(d);

    // Load to x0 never stalls
    step(mk(32'h200, 5'd1, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0));
    step(mk(32'h204, 5'd0, 5'd0, 5'd4, 1'b0, 1'b0, 1'b0));

    // Flush wins over a simultaneous load-use
    step(mk(32'h300, 5'd1, 5'd2, 5'd7, 1'b1, 1'b0, 1'b0));
    step(mk(32'h304, 5'd1, 5'd7, 5'd8, 1'b0, 1'b1, 1'b0));

    // External stall for three cycles with changing ID, hazard pending underneath
    step(mk(32'h400, 5'd1, 5'd2, 5'd9, 1'b1, 1'b0, 1'b0));
    for (int i = 0; i < 3; i++)
      step(mk(32'h404 + 32'(i * 4), 5'd9, 5'(i), 5'd10, 1'b0, 1'b0, 1'b1));
    d = mk(32'h410, 5'd9, 5'd1, 5'd11, 1'b0, 1'b0, 1'b0);
    step(d);
    step(d);

    // Back-to-back loads to the same Rd each stall once
    step(mk(32'h500, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0));
    d = mk(32'h504, 5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0);
    step(d);
    step(d);
    d = mk(32'h508, 5'd5, 5'd2, 5'd6, 1'b0, 1'b0, 1'b0);
    step(d);
    step(d);

    // Invalid ID slot never stalls and loads a bubble
    step(mk(32'h600, 5'd1, 5'd0, 5'd3, 1'b1, 1'b0, 1'b0));
    d = mk(32'h604, 5'd3, 5'd3, 5'd4, 1'b0, 1'b0, 1'b0);
    d.valid = 1'b0;
    step(d);

`ifdef ID_EX_PERF_CNT_EN
    // Counter wrap from all ones on the next load-use bubble
    force dut.bubble_cnt_reg = 32'hFFFF_FFFF;
    #1;
    release dut.bubble_cnt_reg;
    m_cnt = 32'hFFFF_FFFF;
    step(mk(32'h700, 5'd1, 5'd0, 5'd12, 1'b1, 1'b0, 1'b0));
    step(mk(32'h704, 5'd12, 5'd0, 5'd13, 1'b0, 1'b0, 1'b0));
    step(mk(32'h704, 5'd12, 5'd0, 5'd13, 1'b0, 1'b0, 1'b0));
`endif

    // Randomized traffic, holding a stalled instruction occasionally, rare resets
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        d = rand_id();
        step(d);
        if (ex_q.size() == 0 && $urandom_range(0, 1) == 1) begin
          d.stall = 1'b0;
          d.flush = 1'b0;
          step(d);
        end
      end
    end

    repeat (3) @(posedge clk);
    n_checks++;
    if (comb_q.size() != 0 || ex_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d/%0d pending, want 0/0",
               comb_q.size(), ex_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
